// File: rtl/msf_pkg.sv
// rtl/msf_pkg.sv - shared MSF timing defaults and derivation helpers
package msf_pkg;

    localparam int CLK_FREQ_DEF = 12500;
    localparam int BIT_RATE_DEF = 10;

    // How a filtered edge is treated by the phase tracker.
    typedef enum logic [1:0] {
        EDGE_NONE    = 2'd0,
        EDGE_ON_TIME = 2'd1,
        EDGE_REJECT  = 2'd2,
        EDGE_RESYNC  = 2'd3
    } edge_class_e;

    function automatic int calc_period(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

    function automatic int calc_centre(input int period);
        return period / 2;
    endfunction

endpackage

// File: rtl/msf_bit_sampler_mv_glitch_filter.sv
// rtl/msf_bit_sampler_mv_glitch_filter.sv - 2-flop synchroniser plus stable-count deglitcher
module msf_bit_sampler_mv_glitch_filter #(
    parameter int GLITCH_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic data_i,
    output logic level_o,
    output logic edge_o
);

    localparam int CNT_W = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_LEN - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has differed for GLITCH_LEN consecutive clocks.
    always_comb begin
        sync1_d = data_i;
        sync2_d = sync1_q;
        level_d = level_q;
        edge_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                edge_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser and filter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/msf_bit_sampler_mv.sv
// rtl/msf_bit_sampler_mv.sv - MSF bit sampler with phase tracking, majority vote and lock
module msf_bit_sampler_mv
    import msf_pkg::*;
#(
    parameter int CLK_FREQ     = CLK_FREQ_DEF,
    parameter int BIT_RATE     = BIT_RATE_DEF,
    parameter int N_VOTES      = 5,
    parameter int VOTE_SPACING = 8,
    parameter int GLITCH_LEN   = 4,
    parameter int EDGE_TOL     = 25,
    parameter int LOCK_EDGES   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic data_i,
    output logic bit_o,
    output logic valid_o,
    output logic unanimous_o,
    output logic locked_o,
    output logic edge_err_o
);

    localparam int PERIOD   = calc_period(CLK_FREQ, BIT_RATE);
    localparam int CENTRE   = calc_centre(PERIOD);
    localparam int HALF_W   = N_VOTES / 2;
    localparam int FIRST_PH = CENTRE - HALF_W * VOTE_SPACING;
    localparam int LAST_PH  = CENTRE + HALF_W * VOTE_SPACING;
    localparam int PH_W     = $clog2(PERIOD);
    localparam int ACC_W    = $clog2(N_VOTES + 1);
    localparam int LCK_W    = $clog2(LOCK_EDGES + 1);

    localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(LAST_PH);
    localparam logic [PH_W-1:0]  PH_TOL_LO = PH_W'(EDGE_TOL);
    localparam logic [PH_W-1:0]  PH_TOL_HI = PH_W'(PERIOD - EDGE_TOL);
    localparam logic [ACC_W-1:0] ACC_HALF  = ACC_W'(HALF_W);
    localparam logic [ACC_W-1:0] ACC_ALL   = ACC_W'(N_VOTES);
    localparam logic [LCK_W-1:0] LOCK_MAX  = LCK_W'(LOCK_EDGES);

    // Parameter sanity: the vote window must sit clear of both on-time edge windows.
    if ((N_VOTES % 2) == 0 || N_VOTES < 1 || N_VOTES > 15) begin : g_bad_votes
        $error("N_VOTES must be odd and within 1..15");
    end
    if ((N_VOTES - 1) * VOTE_SPACING >= PERIOD - 2 * EDGE_TOL) begin : g_bad_window
        $error("vote window does not fit between edge windows");
    end
    if (EDGE_TOL >= FIRST_PH) begin : g_bad_tol
        $error("EDGE_TOL overlaps the first vote sample");
    end
    if (GLITCH_LEN < 1) begin : g_bad_glitch
        $error("GLITCH_LEN must be at least 1");
    end

    logic level_w;
    logic edge_w;

    msf_bit_sampler_mv_glitch_filter #(
        .GLITCH_LEN(GLITCH_LEN)
    ) u_filter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .level_o(level_w),
        .edge_o (edge_w)
    );

    logic [PH_W-1:0]  ph_q, ph_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ones_w;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             unan_q, unan_d;
    logic             locked_q, locked_d;
    logic             edge_err_q, edge_err_d;
    logic             is_sample;
    edge_class_e      edge_cls;

    // Detect vote sample points and classify the current filtered edge against bit phase.
    always_comb begin
        is_sample = 1'b0;
        for (int k = 0; k < N_VOTES; k++) begin
            if (ph_q == PH_W'(FIRST_PH + k * VOTE_SPACING)) begin
                is_sample = 1'b1;
            end
        end
        edge_cls = EDGE_NONE;
        if (edge_w) begin
            if (ph_q <= PH_TOL_LO || ph_q >= PH_TOL_HI) begin
                edge_cls = EDGE_ON_TIME;
            end else if (locked_q) begin
                edge_cls = EDGE_REJECT;
            end else begin
                edge_cls = EDGE_RESYNC;
            end
        end
    end

    // Next phase, vote accumulation, output bit and lock tracking.
    always_comb begin
        logic zero_ph;
        zero_ph    = (ph_q == PH_MAX) || (edge_cls == EDGE_ON_TIME) || (edge_cls == EDGE_RESYNC);
        ph_d       = zero_ph ? '0 : ph_q + PH_W'(1);
        ones_w     = acc_q + ACC_W'(is_sample && level_w);
        acc_d      = zero_ph ? '0 : (is_sample ? ones_w : acc_q);

        // A resync on the last sample throws the whole window away.
        valid_d    = (ph_q == PH_LAST) && !zero_ph;
        bit_d      = bit_q;
        unan_d     = unan_q;
        if (valid_d) begin
            bit_d  = (ones_w > ACC_HALF);
            unan_d = (ones_w == '0) || (ones_w == ACC_ALL);
        end

        lock_cnt_d = lock_cnt_q;
        edge_err_d = 1'b0;
        case (edge_cls)
            EDGE_ON_TIME: begin
                if (lock_cnt_q != LOCK_MAX) begin
                    lock_cnt_d = lock_cnt_q + LCK_W'(1);
                end
            end
            EDGE_REJECT, EDGE_RESYNC: begin
                lock_cnt_d = '0;
                edge_err_d = 1'b1;
            end
            default: ;
        endcase
        locked_d = (lock_cnt_d == LOCK_MAX);
    end

    // Tracker and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph_q       <= '0;
            acc_q      <= '0;
            lock_cnt_q <= '0;
            bit_q      <= 1'b0;
            valid_q    <= 1'b0;
            unan_q     <= 1'b0;
            locked_q   <= 1'b0;
            edge_err_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            acc_q      <= acc_d;
            lock_cnt_q <= lock_cnt_d;
            bit_q      <= bit_d;
            valid_q    <= valid_d;
            unan_q     <= unan_d;
            locked_q   <= locked_d;
            edge_err_q <= edge_err_d;
        end
    end

    assign bit_o       = bit_q;
    assign valid_o     = valid_q;
    assign unanimous_o = unan_q;
    assign locked_o    = locked_q;
    assign edge_err_o  = edge_err_q;

endmodule

// File: tb/tb_msf_bit_sampler_mv.sv
// tb/tb_msf_bit_sampler_mv.sv - directed self-checking bench for msf_bit_sampler_mv
module tb_msf_bit_sampler_mv;

    logic clk = 1'b0;
    logic rst;
    logic data;
    logic bit_o;
    logic valid_o;
    logic unanimous_o;
    logic locked_o;
    logic edge_err_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nvalid = 0;
    int nerr  = 0;

    always #5 clk = ~clk;

    msf_bit_sampler_mv dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (data),
        .bit_o      (bit_o),
        .valid_o    (valid_o),
        .unanimous_o(unanimous_o),
        .locked_o   (locked_o),
        .edge_err_o (edge_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the negedge following posedge number t (counted from reset release).
    task automatic run_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (valid_o === 1'b1) nvalid++;
            if (edge_err_o === 1'b1) nerr++;
        end
    endtask

    task automatic chk_valid_bit(input string tag, input logic b, input logic u);
        chk({tag, "_valid"}, valid_o, 1'b1);
        chk({tag, "_bit"}, bit_o, b);
        chk({tag, "_unan"}, unanimous_o, u);
    endtask

    initial begin
        rst  = 1'b1;
        data = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bit", bit_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_unan", unanimous_o, 1'b0);
        chk("rst_locked", locked_o, 1'b0);
        chk("rst_err", edge_err_o, 1'b0);
        rst = 1'b0;
        cyc = 0;

        // 1: clean bits 0,1,0,1,1 with edges on period boundaries
        run_to(641);  chk("t1_pre_valid", valid_o, 1'b0);
        run_to(642);  chk_valid_bit("t1_b0", 1'b0, 1'b1);
        run_to(643);  chk("t1_post_valid", valid_o, 1'b0);
        run_to(1243); data = 1'b1;
        run_to(1892); chk_valid_bit("t1_b1", 1'b1, 1'b1);
        run_to(2493); data = 1'b0;
        run_to(3142); chk_valid_bit("t1_b2", 1'b0, 1'b1);
        run_to(3743); data = 1'b1;
        run_to(4392); chk_valid_bit("t1_b3", 1'b1, 1'b1);
        run_to(5642); chk_valid_bit("t1_b4", 1'b1, 1'b1);
        chk("t1_nvalid", nvalid, 5);
        chk("t1_nerr", nerr, 0);
        chk("t1_locked", locked_o, 1'b0);

        // 2: 3-clock glitch ignored, 4-clock glitch seen as off-time edges
        run_to(6700); data = 1'b0;
        run_to(6703); data = 1'b1;
        run_to(6892); chk_valid_bit("t2_glitch3", 1'b1, 1'b1);
        chk("t2_nerr3", nerr, 0);
        run_to(7800); data = 1'b0;
        run_to(7804); data = 1'b1;
        run_to(7806); chk("t2_err_pre", edge_err_o, 1'b0);
        run_to(7807); chk("t2_err", edge_err_o, 1'b1);
        run_to(7808); chk("t2_err_post", edge_err_o, 1'b0);
        run_to(8142); chk("t2_old_sched", valid_o, 1'b0);
        run_to(8453); chk_valid_bit("t2_resync", 1'b1, 1'b1);
        chk("t2_nvalid", nvalid, 7);
        chk("t2_nerr", nerr, 1);

        // 3: lock after four on-time edges, then off-time edge at ph=300 while locked
        run_to(9054);  data = 1'b0;
        run_to(10304); data = 1'b1;
        run_to(10953); chk_valid_bit("t3_b", 1'b1, 1'b1);
        run_to(11554); data = 1'b0;
        run_to(11560); chk("t3_lock_pre", locked_o, 1'b0);
        run_to(11561); chk("t3_lock", locked_o, 1'b1);
        run_to(11855); data = 1'b1;
        run_to(11861); chk("t3_err_pre", edge_err_o, 1'b0);
        chk("t3_lock_hold", locked_o, 1'b1);
        run_to(11862); chk("t3_err", edge_err_o, 1'b1);
        chk("t3_lock_drop", locked_o, 1'b0);
        run_to(11863); chk("t3_err_post", edge_err_o, 1'b0);
        run_to(12202); chk("t3_sched_pre", valid_o, 1'b0);
        run_to(12203); chk_valid_bit("t3_sched", 1'b1, 1'b1);
        chk("t3_nerr", nerr, 2);

        // 4: relock, then late-window low pulse corrupting the last two samples
        run_to(12804); data = 1'b0;
        run_to(14054); data = 1'b1;
        run_to(15304); data = 1'b0;
        run_to(16554); data = 1'b1;
        run_to(16561); chk("t4_lock", locked_o, 1'b1);
        run_to(17185); data = 1'b0;
        run_to(17191); chk("t4_lock_hold", locked_o, 1'b1);
        run_to(17192); chk("t4_err1", edge_err_o, 1'b1);
        chk("t4_lock_drop", locked_o, 1'b0);
        run_to(17203); chk_valid_bit("t4_vote", 1'b1, 1'b0);
        run_to(17205); data = 1'b1;
        run_to(17212); chk("t4_err2", edge_err_o, 1'b1);
        chk("t4_nerr", nerr, 4);
        chk("t4_nvalid", nvalid, 14);

        // 5: reset mid vote window (ph=620)
        run_to(17832); chk("t5_bit_before", bit_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rst_bit", bit_o, 1'b0);
        chk("t5_rst_valid", valid_o, 1'b0);
        chk("t5_rst_unan", unanimous_o, 1'b0);
        chk("t5_rst_locked", locked_o, 1'b0);
        chk("t5_rst_err", edge_err_o, 1'b0);
        data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_rst_hold_valid", valid_o, 1'b0);
        end
        rst = 1'b0;
        cyc = 0;
        run_to(641); chk("t5_pre_valid", valid_o, 1'b0);
        run_to(642); chk_valid_bit("t5_first", 1'b0, 1'b1);
        chk("t5_locked", locked_o, 1'b0);
        chk("t5_nvalid", nvalid, 15);

        // 6: lock, then three silent periods
        run_to(1243); data = 1'b1;
        run_to(2493); data = 1'b0;
        run_to(3743); data = 1'b1;
        run_to(4993); data = 1'b0;
        run_to(5000); chk("t6_lock", locked_o, 1'b1);
        chk("t6_nvalid0", nvalid, 18);
        run_to(5641); chk("t6_pre_valid", valid_o, 1'b0);
        run_to(5642); chk_valid_bit("t6_v1", 1'b0, 1'b1);
        chk("t6_lock1", locked_o, 1'b1);
        run_to(6892); chk_valid_bit("t6_v2", 1'b0, 1'b1);
        chk("t6_lock2", locked_o, 1'b1);
        run_to(8142); chk_valid_bit("t6_v3", 1'b0, 1'b1);
        chk("t6_lock3", locked_o, 1'b1);
        run_to(8143); chk("t6_post_valid", valid_o, 1'b0);
        chk("t6_nvalid", nvalid, 21);
        chk("t6_nerr", nerr, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
